rew_mask_apply: RTL and testbench

- Consumer end of the REW AES mask path, in the slow (DRAM-side) clock domain.
- Joins the plaintext bucket stream headed for DRAM with the RW mask stream (DDRDWidth mask words; header mask words first, then payload mask words) and emits ciphertext words one-for-one, in order.
- Tracks bucket boundaries so header words keep their IV field in the clear while payload words are fully masked.
- Output feeds the DRAM write-data path.

---
 rtl/rew_mask_apply_pkg.sv | 16 +
 rtl/rew_mask_apply_if.sv | 15 +
 rtl/rew_mask_apply.sv | 46 ++++
 tb/tb_rew_mask_apply.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rew_mask_apply_pkg.sv
// rew_mask_apply_pkg: geometry shared by the REW mask applier and its bench
package rew_mask_apply_pkg;
  localparam int DDR_D_WIDTH = 512;
  localparam int IV_ENTROPY_WIDTH = 64;
  localparam int BKT_HEADER_DR_WORDS = 1;
  localparam int BLK_DR_WORDS = 4;
  localparam int ORAM_Z = 4;
  localparam int BKT_WORDS = BKT_HEADER_DR_WORDS + ORAM_Z * BLK_DR_WORDS;
  localparam int WC_W = $clog2(BKT_WORDS) + 1;
  typedef logic [DDR_D_WIDTH-1:0] word_t;
  typedef logic [WC_W-1:0] wc_t;
  typedef enum logic {PH_HEADER, PH_PAYLOAD} phase_e;
  function automatic word_t header_mask(word_t m);
    return {m[DDR_D_WIDTH-1:IV_ENTROPY_WIDTH], {IV_ENTROPY_WIDTH{1'b0}}};
  endfunction
endpackage

// File: rtl/rew_mask_apply_if.sv
// rew_mask_apply_if: plaintext, mask and ciphertext streams of the REW mask applier
interface rew_mask_apply_if;
  import rew_mask_apply_pkg::*;
  word_t data_in, mask_in, data_out;
  logic data_in_valid, data_in_ready, mask_in_valid, mask_in_ready;
  logic data_out_valid, data_out_ready, bucket_done;
  modport master (
    output data_in, data_in_valid, mask_in, mask_in_valid, data_out_ready,
    input data_in_ready, mask_in_ready, data_out, data_out_valid, bucket_done
  );
  modport slave (
    input data_in, data_in_valid, mask_in, mask_in_valid, data_out_ready,
    output data_in_ready, mask_in_ready, data_out, data_out_valid, bucket_done
  );
endinterface

// File: rtl/rew_mask_apply.sv
// rew_mask_apply: XORs the bucket stream with RW mask words, keeping header IV bits clear
module rew_mask_apply
  import rew_mask_apply_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  rew_mask_apply_if.slave bus_io
);
  wc_t wc_q, wc_d;
  word_t data_q, data_d;
  logic valid_q, valid_d, done_q, done_d, out_free, fire, last;
  phase_e phase;
  always_comb begin
    out_free = ~valid_q | bus_io.data_out_ready;
    fire = bus_io.data_in_valid & bus_io.mask_in_valid & out_free & ~rst_i;
    last = wc_q == wc_t'(BKT_WORDS - 1);
    phase = wc_q < wc_t'(BKT_HEADER_DR_WORDS) ? PH_HEADER : PH_PAYLOAD;
    wc_d = fire ? (last ? '0 : wc_q + 1'b1) : wc_q;
    data_d = fire ? bus_io.data_in ^ (phase == PH_HEADER ? header_mask(bus_io.mask_in) : bus_io.mask_in) : data_q;
    valid_d = fire | (valid_q & ~bus_io.data_out_ready);
    done_d = fire ? last : done_q & ~bus_io.data_out_ready;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wc_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wc_q <= wc_d;
      data_q <= data_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  // each ready depends only on the other stream, so both are consumed together
  assign bus_io.data_in_ready = bus_io.mask_in_valid & out_free & ~rst_i;
  assign bus_io.mask_in_ready = bus_io.data_in_valid & out_free & ~rst_i;
  assign bus_io.data_out = data_q;
  assign bus_io.data_out_valid = valid_q;
  assign bus_io.bucket_done = done_q;
`ifdef SIMULATION
  assert property (@(posedge clk_i) $fell(rst_i) |-> !valid_q)
    else $error("rew_mask_apply: output valid at reset release");
`endif
endmodule

// File: tb/tb_rew_mask_apply.sv
// tb_rew_mask_apply: directed tables plus randomized streams against a bucket-level scoreboard
module tb_rew_mask_apply;
  import rew_mask_apply_pkg::*;
  typedef struct {word_t din; word_t mask; word_t dout; logic done;} vec_t;
  typedef struct {word_t d; logic done; int cyc;} obs_t;
  logic clk = 1'b0, rst = 1'b1;
  rew_mask_apply_if bus ();
  rew_mask_apply dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));
  always #5 clk = ~clk;
  int checks = 0, passed = 0, cyc = 0, fires = 0, dones = 0, nwords = 0;
  logic fire_s = 1'b0, prev_hold = 1'b0, prev_done = 1'b0, free_s;
  logic d_en = 1'b0, m_en = 1'b0, r_en = 1'b0;
  word_t prev_d, ones;
  word_t src_d[$], src_m[$], exp_d[$];
  logic exp_done[$];
  obs_t got[$];

  function automatic word_t rnd_word();
    word_t w;
    for (int i = 0; i < DDR_D_WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // k is the word's position within its bucket; header words leave the IV field in the clear
  function automatic word_t cipher(word_t d, word_t m, int k);
    word_t keep = '0;
    if (k < BKT_HEADER_DR_WORDS)
      for (int i = 0; i < IV_ENTROPY_WIDTH; i++) keep[i] = 1'b1;
    return d ^ (m & ~keep);
  endfunction

  task automatic chk(string name, logic ok, word_t act, word_t req);
    checks++;
    if (ok === 1'b1) passed++;
    else $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, req);
  endtask

  always @(negedge clk) begin
    cyc++;
    fire_s = bus.data_in_valid & bus.data_in_ready;
    if (rst) begin
      chk("rst_readies", !bus.data_in_ready && !bus.mask_in_ready, word_t'({bus.data_in_ready, bus.mask_in_ready}), '0);
      exp_d.delete();
      exp_done.delete();
      nwords = 0;
      prev_hold = 1'b0;
    end else begin
      free_s = !bus.data_out_valid || bus.data_out_ready;
      chk("data_in_ready", bus.data_in_ready === (bus.mask_in_valid & free_s), word_t'(bus.data_in_ready), word_t'(bus.mask_in_valid & free_s));
      chk("mask_in_ready", bus.mask_in_ready === (bus.data_in_valid & free_s), word_t'(bus.mask_in_ready), word_t'(bus.data_in_valid & free_s));
      if (prev_hold) begin
        chk("hold_data", bus.data_out === prev_d, bus.data_out, prev_d);
        chk("hold_valid_done", bus.data_out_valid === 1'b1 && bus.bucket_done === prev_done,
            word_t'({bus.data_out_valid, bus.bucket_done}), word_t'({1'b1, prev_done}));
      end
      if (!bus.data_out_valid) chk("done_idle", bus.bucket_done === 1'b0, word_t'(bus.bucket_done), '0);
      if (bus.data_out_valid && bus.data_out_ready) begin
        if (exp_d.size() == 0) chk("spurious_out", 1'b0, bus.data_out, '0);
        else begin
          chk("data_out", bus.data_out === exp_d[0], bus.data_out, exp_d[0]);
          chk("bucket_done", bus.bucket_done === exp_done[0], word_t'(bus.bucket_done), word_t'(exp_done[0]));
          void'(exp_d.pop_front());
          void'(exp_done.pop_front());
        end
        got.push_back('{bus.data_out, bus.bucket_done, cyc});
        if (bus.bucket_done) dones++;
      end
      if (fire_s) begin
        exp_d.push_back(cipher(bus.data_in, bus.mask_in, nwords % BKT_WORDS));
        exp_done.push_back(nwords % BKT_WORDS == BKT_WORDS - 1);
        nwords++;
        fires++;
      end
      prev_hold = bus.data_out_valid && !bus.data_out_ready;
      prev_d = bus.data_out;
      prev_done = bus.bucket_done;
    end
  end

  task automatic apply();
    bus.data_in_valid = d_en && src_d.size() > 0;
    bus.mask_in_valid = m_en && src_m.size() > 0;
    bus.data_in = src_d.size() > 0 ? src_d[0] : '0;
    bus.mask_in = src_m.size() > 0 ? src_m[0] : '0;
    bus.data_out_ready = r_en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fire_s) begin
      void'(src_d.pop_front());
      void'(src_m.pop_front());
    end
    apply();
  endtask

  task automatic drive(logic d, logic m, logic r);
    d_en = d;
    m_en = m;
    r_en = r;
    apply();
  endtask

  task automatic push(word_t d, word_t m);
    src_d.push_back(d);
    src_m.push_back(m);
  endtask

  task automatic wait_fires(int n, string name);
    int t = 0;
    while (fires < n && t < 200) begin step(); t++; end
    if (fires < n) chk(name, 1'b0, word_t'(fires), word_t'(n));
  endtask

  task automatic wait_got(int n, string name);
    int t = 0;
    while (got.size() < n && t < 400) begin step(); t++; end
    if (got.size() < n) chk(name, 1'b0, word_t'(got.size()), word_t'(n));
  endtask

  initial begin
    vec_t tbl[BKT_WORDS];
    word_t da[2*BKT_WORDS], ma[2*BKT_WORDS];
    word_t w;
    int f0, g0, d0, sent;
    ones = '1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) step();
    chk("reset_state", bus.data_out_valid === 1'b0 && bus.bucket_done === 1'b0 && bus.data_out === '0, bus.data_out, '0);
    rst = 1'b0;
    // 1: one bucket, data = index, mask all ones
    for (int i = 0; i < BKT_WORDS; i++) begin
      tbl[i].din = word_t'(i);
      tbl[i].mask = ones;
      tbl[i].dout = i == 0 ? ones << IV_ENTROPY_WIDTH : ~word_t'(i);
      tbl[i].done = i == BKT_WORDS - 1;
      push(tbl[i].din, tbl[i].mask);
    end
    g0 = got.size();
    drive(1'b1, 1'b1, 1'b1);
    wait_got(g0 + BKT_WORDS, "t1_timeout");
    if (got.size() >= g0 + BKT_WORDS) begin
      for (int i = 0; i < BKT_WORDS; i++) begin
        chk("t1_word", got[g0+i].d === tbl[i].dout, got[g0+i].d, tbl[i].dout);
        chk("t1_done", got[g0+i].done === tbl[i].done, word_t'(got[g0+i].done), word_t'(tbl[i].done));
      end
      chk("t1_last_word_spacing", got[g0+BKT_WORDS-1].cyc - got[g0].cyc == BKT_WORDS - 1,
          word_t'(got[g0+BKT_WORDS-1].cyc - got[g0].cyc), word_t'(BKT_WORDS - 1));
    end
    // 2: mask stream stalls for 3 cycles after word 5
    f0 = fires;
    g0 = got.size();
    for (int i = 0; i < BKT_WORDS; i++) begin da[i] = rnd_word(); ma[i] = rnd_word(); push(da[i], ma[i]); end
    wait_fires(f0 + 6, "t2_timeout");
    drive(1'b1, 1'b0, 1'b1);
    repeat (3) begin
      step();
      #1;
      chk("t2_stall_ready", bus.data_in_ready === 1'b0, word_t'(bus.data_in_ready), '0);
    end
    chk("t2_no_fire", fires == f0 + 6, word_t'(fires - f0), word_t'(6));
    drive(1'b1, 1'b1, 1'b1);
    wait_got(g0 + BKT_WORDS, "t2_drain");
    if (got.size() >= g0 + BKT_WORDS)
      chk("t2_word6", got[g0+6].d === cipher(da[6], ma[6], 6), got[g0+6].d, cipher(da[6], ma[6], 6));
    // 3: downstream backpressure for 5 cycles with word 3 on the output
    f0 = fires;
    g0 = got.size();
    for (int i = 0; i < BKT_WORDS; i++) begin da[i] = rnd_word(); ma[i] = rnd_word(); push(da[i], ma[i]); end
    wait_fires(f0 + 4, "t3_timeout");
    drive(1'b1, 1'b1, 1'b0);
    #1;
    w = bus.data_out;
    chk("t3_word3_held", w === cipher(da[3], ma[3], 3), w, cipher(da[3], ma[3], 3));
    repeat (5) begin
      step();
      #1;
      chk("t3_stable", bus.data_out === w && bus.data_out_valid === 1'b1 && !bus.data_in_ready && !bus.mask_in_ready, bus.data_out, w);
    end
    chk("t3_no_fire", fires == f0 + 4, word_t'(fires - f0), word_t'(4));
    drive(1'b1, 1'b1, 1'b1);
    wait_got(g0 + BKT_WORDS, "t3_drain");
    if (got.size() >= g0 + BKT_WORDS)
      for (int i = 3; i < 5; i++)
        chk("t3_order", got[g0+i].d === cipher(da[i], ma[i], i), got[g0+i].d, cipher(da[i], ma[i], i));
    // 4: two buckets back to back with all-ones mask
    g0 = got.size();
    for (int i = 0; i < 2 * BKT_WORDS; i++) begin da[i] = rnd_word(); push(da[i], ones); end
    wait_got(g0 + 2 * BKT_WORDS, "t4_timeout");
    if (got.size() >= g0 + 2 * BKT_WORDS)
      for (int j = 0; j < 2 * BKT_WORDS; j++) begin
        w = j % BKT_WORDS == 0 ? da[j] : ~da[j];
        chk("t4_iv", got[g0+j].d[IV_ENTROPY_WIDTH-1:0] === w[IV_ENTROPY_WIDTH-1:0], got[g0+j].d, w);
        chk("t4_done", got[g0+j].done === (j % BKT_WORDS == BKT_WORDS - 1), word_t'(got[g0+j].done), word_t'(j % BKT_WORDS == BKT_WORDS - 1));
        if (j > 0) chk("t4_rate", got[g0+j].cyc - got[g0+j-1].cyc == 1, word_t'(got[g0+j].cyc - got[g0+j-1].cyc), word_t'(1));
      end
    // 5: reset one cycle after word 9 fires, then a fresh bucket
    f0 = fires;
    for (int i = 0; i < BKT_WORDS; i++) push(rnd_word(), rnd_word());
    wait_fires(f0 + 10, "t5_timeout");
    step();
    rst = 1'b1;
    step();
    chk("t5_reset_out", bus.data_out_valid === 1'b0 && bus.bucket_done === 1'b0 && bus.data_out === '0, bus.data_out, '0);
    rst = 1'b0;
    src_d.delete();
    src_m.delete();
    g0 = got.size();
    for (int i = 0; i < BKT_WORDS; i++) begin da[i] = rnd_word(); push(da[i], ones); end
    drive(1'b1, 1'b1, 1'b1);
    wait_got(g0 + BKT_WORDS, "t5_drain");
    if (got.size() >= g0 + BKT_WORDS) begin
      w = da[0] ^ (ones << IV_ENTROPY_WIDTH);
      chk("t5_header_after_reset", got[g0].d === w, got[g0].d, w);
      chk("t5_done", got[g0+BKT_WORDS-1].done === 1'b1, word_t'(got[g0+BKT_WORDS-1].done), word_t'(1));
    end
    // 6: random valid/ready on all three streams
    d0 = dones;
    sent = 0;
    for (int t = 0; t < 60000 && (sent < 1000 * BKT_WORDS || exp_d.size() > 0 || src_d.size() > 0); t++) begin
      while (src_d.size() < 4 && sent < 1000 * BKT_WORDS) begin push(rnd_word(), rnd_word()); sent++; end
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
      step();
    end
    drive(1'b0, 1'b0, 1'b1);
    chk("t6_buckets", dones - d0 == 1000, word_t'(dones - d0), word_t'(1000));
    chk("t6_drained", exp_d.size() == 0 && src_d.size() == 0, word_t'(exp_d.size()), '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
